// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters, with bounded bursts.
// Latency: 0 cycles from IDLE; grant/wr/data are combinational from state and current inputs.
// Backpressure: fifo_full blocks every grant in the same cycle; an owner stalls without losing its burst.
module fifo_wr_arbiter #(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_REQ    = 4,
    parameter  int MAX_BURST  = 2,
    localparam int IW         = $clog2(NUM_REQ),
    localparam int CW         = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_w_data,
    output logic                          busy,
    output logic [IW-1:0]                 owner
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   rr_nxt;
    logic [IW-1:0]   owner_nxt;
    logic [CW-1:0]   burst_cnt;
    logic [CW-1:0]   cnt_nxt;

    logic            found;
    logic [IW-1:0]   pick;
    int              scan_idx;

    // Wrap-around increment; NUM_REQ need not be a power of two.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] x);
        return (x == IW'(NUM_REQ - 1)) ? '0 : x + IW'(1);
    endfunction

    // Find the first requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        scan_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                pick  = IW'(scan_idx);
            end
        end
    end

    // Next-state and Mealy grant; reset and fifo_full both suppress every grant.
    always_comb begin
        gnt       = '0;
        state_nxt = state;
        rr_nxt    = rr_ptr;
        owner_nxt = owner;
        cnt_nxt   = burst_cnt;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (found && !fifo_full) begin
                        gnt[pick] = 1'b1;
                        if (MAX_BURST == 1) begin
                            rr_nxt = next_idx(pick);
                        end else begin
                            owner_nxt = pick;
                            cnt_nxt   = CW'(1);
                            state_nxt = OWN;
                        end
                    end
                end
                OWN: begin
                    if (req[owner]) begin
                        // Owner still wants the port; a full FIFO just stalls the burst.
                        if (!fifo_full) begin
                            gnt[owner] = 1'b1;
                            if ((burst_cnt + CW'(1)) == CW'(MAX_BURST)) begin
                                rr_nxt    = next_idx(owner);
                                owner_nxt = '0;
                                cnt_nxt   = '0;
                                state_nxt = IDLE;
                            end else begin
                                cnt_nxt = burst_cnt + CW'(1);
                            end
                        end
                    end else begin
                        // Early release costs one bubble cycle with no grant.
                        rr_nxt    = next_idx(owner);
                        owner_nxt = '0;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Write-port drive: the granted word, or zero when nobody is granted.
    always_comb begin
        fifo_w_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                fifo_w_data = fifo_w_data | req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        fifo_wr = |gnt;
        busy    = !reset && (state == OWN);
    end

    // State registers with synchronous reset; a reset mid-burst abandons the burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            owner     <= owner_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `FIFO` write port among `NUM_REQ` requesters. It sits directly in front of the FIFO's `wr`/`w_data`/`full` pins and grants one requester per cycle. A granted requester may hold the port for a bounded burst of consecutive beats. It never writes while the FIFO reports full, so no requester is starved and no data is dropped.

## Interface
- `DATA_WIDTH`, 8, width of each requester word and of `fifo_w_data`
- `NUM_REQ`, 4, number of requesters, ≥ 2
- `MAX_BURST`, 2, maximum consecutive beats per ownership, ≥ 1

- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req`  in  NUM_REQ  per-requester write request; `req_data` valid while high
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed words; requester k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- `gnt`  out  NUM_REQ  one-hot or zero; `gnt[k]`=1 means requester k's word is written at this rising edge
- `fifo_full`  in  1  from FIFO `full`
- `fifo_wr`  out  1  to FIFO `wr`; equals OR of `gnt`
- `fifo_w_data`  out  DATA_WIDTH  to FIFO `w_data`; granted word, or all-zero when no grant
- `busy`  out  1  high while in OWN state
- `owner`  out  clog2(NUM_REQ)  current burst owner; 0 when idle

## Operation
- State registers:
  - `state` ∈ {IDLE, OWN}
  - `rr_ptr`: highest-priority index
  - `owner`
  - `burst_cnt`: width clog2(MAX_BURST+1)
- Reset values: state=IDLE, rr_ptr=0, owner=0, burst_cnt=0.
- While `reset`=1: gnt=0, fifo_wr=0, fifo_w_data=0, busy=0, regardless of inputs.
- Outputs `gnt`, `fifo_wr` and `fifo_w_data` are combinational from state and current inputs (Mealy). The consumer samples them at the rising edge.
- Global rule: `fifo_full`=1 forces gnt=0 and fifo_wr=0 in every state.
- IDLE:
  - If `|req` and !fifo_full: select k = first index with req set, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ. Assert gnt[k].
  - If MAX_BURST=1: rr_ptr←(k+1) mod NUM_REQ; remain IDLE.
  - Otherwise: owner←k, burst_cnt←1, state←OWN.
  - No request, or full: no state change.
- OWN:
  - req[owner]=1 and !fifo_full: gnt[owner]=1.
    - If burst_cnt+1 = MAX_BURST: rr_ptr←(owner+1) mod NUM_REQ, burst_cnt←0, state←IDLE.
    - Otherwise burst_cnt←burst_cnt+1.
  - req[owner]=1 and fifo_full: stall. No grant; burst_cnt, owner and state unchanged.
  - req[owner]=0: release with no grant this cycle (one bubble). rr_ptr←(owner+1) mod NUM_REQ, burst_cnt←0, state←IDLE.
  - Other requesters' `req` is ignored while in OWN.
- Requester obligation: hold `req` and `req_data` stable until `gnt` is seen. The arbiter does not buffer data.

## Timing
- Grant latency from IDLE: 0 cycles. The first beat is written at the first rising edge where req is high and the FIFO is not full.
- Burst of MAX_BURST beats completes in MAX_BURST cycles absent full.
- The next requester is granted the cycle after release.
- Early release (owner deasserts `req`) costs one idle cycle.
- `fifo_full` sampled high blocks the write in that same cycle, so the FIFO never sees wr=1 with full=1.
- Wrap-around: pointer arithmetic is modulo NUM_REQ. Owner NUM_REQ-1 releasing sets rr_ptr=0.
- Reset asserted mid-burst:
  - Outputs go to 0 in that cycle.
  - State returns to IDLE with rr_ptr=0 at the edge.
  - The partial burst is abandoned.

## Test plan
All scenarios use NUM_REQ=4, MAX_BURST=2, DATA_WIDTH=8 and the 8-deep FIFO.
- **Round-robin with burst limit.** After reset, req=4'b1010 with data r1=0x11, r3=0x33, held. Required:
  - gnt sequence 0010, 0010, 1000, 1000, 0010, …
  - fifo_w_data sequence 0x11, 0x11, 0x33, 0x33, 0x11, …
  - busy=1 on each second beat's cycle.
- **Full stall mid-burst.** Owner 0 after 1 beat; fifo_full=1 for 3 cycles. Required:
  - gnt=0 and fifo_wr=0 for those 3 cycles, owner stays 0.
  - When full drops, one more beat to req0, then release to next requester.
- **Early release.** Owner 2 drops req after 1 beat, with req=4'b0011 still pending. Required:
  - One cycle with gnt=0.
  - Next cycle gnt=4'b0001 (pointer wrapped 3→0).
- **Reset mid-burst.** Assert reset while owner=3, burst_cnt=1. Required:
  - gnt=0, fifo_wr=0 during reset.
  - After release with req=4'b1111, first grant is 4'b0001.
- **FIFO integration.** Four requesters each hold distinct data (0xA0+k). Required:
  - Exactly 8 writes occur, then full=1 and fifo_wr stays 0.
  - Draining 8 reads returns A0,A0,A1,A1,A2,A2,A3,A3 in order.
- **MAX_BURST=1 variant.** req=4'b1111 with full=0. Required: gnt rotates 0001, 0010, 0100, 1000, 0001, with busy=0 throughout.
